// File: rtl/accelerator_state_matrix_input_feedback_if.sv
// Handshake and data bus of the closed-loop input-matrix engine b = B*(I-P).
//   START, READY                 : transaction start / one-cycle done pulse
//   DATA_B_IN_*, DATA_P_IN_*     : streamed B (IxJ) and P (JxJ) elements with I/J strobes
//   SIZE_B_I_IN, SIZE_B_J_IN     : matrix dimensions, latched at START
//   DATA_B_OUT, DATA_B_OUT_*     : row-major result stream with I/J strobes
// master drives the inputs of the engine; slave is the engine itself.
interface accelerator_state_matrix_input_feedback_if #(
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned CONTROL_SIZE = 64
);
   logic                    START;
   logic                    READY;
   logic                    DATA_B_IN_I_ENABLE;
   logic                    DATA_B_IN_J_ENABLE;
   logic                    DATA_P_IN_I_ENABLE;
   logic                    DATA_P_IN_J_ENABLE;
   logic                    DATA_B_OUT_I_ENABLE;
   logic                    DATA_B_OUT_J_ENABLE;
   logic [CONTROL_SIZE-1:0] SIZE_B_I_IN;
   logic [CONTROL_SIZE-1:0] SIZE_B_J_IN;
   logic [DATA_SIZE-1:0]    DATA_B_IN;
   logic [DATA_SIZE-1:0]    DATA_P_IN;
   logic [DATA_SIZE-1:0]    DATA_B_OUT;

   modport master (
      output START, DATA_B_IN_I_ENABLE, DATA_B_IN_J_ENABLE,
             DATA_P_IN_I_ENABLE, DATA_P_IN_J_ENABLE,
             SIZE_B_I_IN, SIZE_B_J_IN, DATA_B_IN, DATA_P_IN,
      input  READY, DATA_B_OUT_I_ENABLE, DATA_B_OUT_J_ENABLE, DATA_B_OUT
   );

   modport slave (
      input  START, DATA_B_IN_I_ENABLE, DATA_B_IN_J_ENABLE,
             DATA_P_IN_I_ENABLE, DATA_P_IN_J_ENABLE,
             SIZE_B_I_IN, SIZE_B_J_IN, DATA_B_IN, DATA_P_IN,
      output READY, DATA_B_OUT_I_ENABLE, DATA_B_OUT_J_ENABLE, DATA_B_OUT
   );
endinterface

// File: rtl/accelerator_state_matrix_input_feedback.sv
// Fixed-point engine computing b = B*(I-P) with a single MAC.
// B (IxJ) and P (JxJ) are buffered, then each b[i][j] is built as
//   (B[i][j] << FRACTION) - sum_m B[i][m]*P[m][j], shifted back by FRACTION.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of accelerator_state_matrix_input_feedback_if
// Optional feature: define ACCELERATOR_STATE_SATURATION_EN to clamp results
// that do not fit DATA_SIZE; otherwise the low DATA_SIZE bits are kept.
module accelerator_state_matrix_input_feedback #(
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned CONTROL_SIZE = 64,
   parameter int unsigned FRACTION     = 16,
   parameter int unsigned MAX_SIZE     = 4
) (
   input logic CLK,
   input logic RST,
   accelerator_state_matrix_input_feedback_if.slave bus
);
   localparam int unsigned CNT_W  = $clog2(MAX_SIZE + 1);
   localparam int unsigned IDX_W  = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
   localparam int unsigned PROD_W = 2 * DATA_SIZE;
   localparam int unsigned ACC_W  = PROD_W + $clog2(MAX_SIZE) + 1;
   localparam int unsigned HI_W   = ACC_W - DATA_SIZE + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_B,
      ST_LOAD_P,
      ST_COMPUTE,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        size_i_q, size_i_d;
   logic [CNT_W-1:0]        size_j_q, size_j_d;
   logic [CNT_W-1:0]        row_q, row_d;
   logic [CNT_W-1:0]        col_q, col_d;
   logic [CNT_W-1:0]        mac_q, mac_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    ready_q, ready_d;
   logic                    out_i_en_q, out_i_en_d;
   logic                    out_j_en_q, out_j_en_d;
   logic [DATA_SIZE-1:0]    dout_q, dout_d;
   logic [DATA_SIZE-1:0]    b_mem_q [MAX_SIZE][MAX_SIZE];
   logic [DATA_SIZE-1:0]    b_mem_d [MAX_SIZE][MAX_SIZE];
   logic [DATA_SIZE-1:0]    p_mem_q [MAX_SIZE][MAX_SIZE];
   logic [DATA_SIZE-1:0]    p_mem_d [MAX_SIZE][MAX_SIZE];

   logic                    size_ok_c;
   logic                    col_last_c;
   logic                    row_last_b_c;
   logic                    row_last_p_c;
   logic                    mac_last_c;
   logic signed [DATA_SIZE-1:0] b_mac_c;
   logic signed [DATA_SIZE-1:0] p_mac_c;
   logic signed [DATA_SIZE-1:0] b_own_c;
   logic signed [PROD_W-1:0]    prod_c;
   logic signed [ACC_W-1:0]     acc_base_c;
   logic signed [ACC_W-1:0]     acc_shift_c;
   logic [HI_W-1:0]             hi_c;
   logic [DATA_SIZE-1:0]        result_c;
   logic                        unused_c;

   // Row-enable strobes are informational; the shifted accumulator's top bits only matter when clamping.
   assign unused_c = ^{bus.DATA_B_IN_I_ENABLE, bus.DATA_P_IN_I_ENABLE, acc_shift_c, hi_c};

   assign size_ok_c = (bus.SIZE_B_I_IN != '0) && (bus.SIZE_B_I_IN <= CONTROL_SIZE'(MAX_SIZE)) &&
                      (bus.SIZE_B_J_IN != '0) && (bus.SIZE_B_J_IN <= CONTROL_SIZE'(MAX_SIZE));

   assign col_last_c   = (col_q == size_j_q - CNT_W'(1));
   assign row_last_b_c = (row_q == size_i_q - CNT_W'(1));
   assign row_last_p_c = (row_q == size_j_q - CNT_W'(1));
   assign mac_last_c   = (mac_q == size_j_q);

   // MAC datapath: operand m = mac_q of row i = row_q against column j = col_q.
   always_comb begin
      b_mac_c     = b_mem_q[IDX_W'(row_q)][IDX_W'(mac_q)];
      p_mac_c     = p_mem_q[IDX_W'(mac_q)][IDX_W'(col_q)];
      b_own_c     = b_mem_q[IDX_W'(row_q)][IDX_W'(col_q)];
      prod_c      = PROD_W'(b_mac_c) * PROD_W'(p_mac_c);
      // First MAC cycle seeds the accumulator with B[i][j] in product scale.
      acc_base_c  = (mac_q == '0) ? (ACC_W'(b_own_c) <<< FRACTION) : acc_q;
      acc_shift_c = acc_q >>> FRACTION;
      hi_c        = acc_shift_c[ACC_W-1:DATA_SIZE-1];
`ifdef ACCELERATOR_STATE_SATURATION_EN
      // Result fits only if all bits above the sign position agree.
      if (!((&hi_c) || !(|hi_c))) begin
         result_c = acc_shift_c[ACC_W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                         : {1'b0, {(DATA_SIZE-1){1'b1}}};
      end else begin
         result_c = acc_shift_c[DATA_SIZE-1:0];
      end
`else
      result_c = acc_shift_c[DATA_SIZE-1:0];
`endif
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      size_i_d   = size_i_q;
      size_j_d   = size_j_q;
      row_d      = row_q;
      col_d      = col_q;
      mac_d      = mac_q;
      acc_d      = acc_q;
      ready_d    = 1'b0;
      out_i_en_d = 1'b0;
      out_j_en_d = 1'b0;
      dout_d     = dout_q;
      b_mem_d    = b_mem_q;
      p_mem_d    = p_mem_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.START) begin
               size_i_d = CNT_W'(bus.SIZE_B_I_IN);
               size_j_d = CNT_W'(bus.SIZE_B_J_IN);
               row_d    = '0;
               col_d    = '0;
               mac_d    = '0;
               state_d  = size_ok_c ? ST_LOAD_B : ST_ERROR;
            end
         end
         ST_LOAD_B: begin
            if (bus.DATA_B_IN_J_ENABLE) begin
               b_mem_d[IDX_W'(row_q)][IDX_W'(col_q)] = bus.DATA_B_IN;
               if (col_last_c) begin
                  col_d = '0;
                  if (row_last_b_c) begin
                     row_d   = '0;
                     state_d = ST_LOAD_P;
                  end else begin
                     row_d = row_q + CNT_W'(1);
                  end
               end else begin
                  col_d = col_q + CNT_W'(1);
               end
            end
         end
         ST_LOAD_P: begin
            if (bus.DATA_P_IN_J_ENABLE) begin
               p_mem_d[IDX_W'(row_q)][IDX_W'(col_q)] = bus.DATA_P_IN;
               if (col_last_c) begin
                  col_d = '0;
                  if (row_last_p_c) begin
                     row_d   = '0;
                     mac_d   = '0;
                     state_d = ST_COMPUTE;
                  end else begin
                     row_d = row_q + CNT_W'(1);
                  end
               end else begin
                  col_d = col_q + CNT_W'(1);
               end
            end
         end
         ST_COMPUTE: begin
            if (!mac_last_c) begin
               acc_d = acc_base_c - ACC_W'(prod_c);
               mac_d = mac_q + CNT_W'(1);
            end else begin
               // Output cycle: register the element and advance (i, j).
               dout_d     = result_c;
               out_j_en_d = 1'b1;
               out_i_en_d = (col_q == '0);
               mac_d      = '0;
               if (col_last_c) begin
                  col_d = '0;
                  if (row_last_b_c) begin
                     row_d   = '0;
                     state_d = ST_DONE;
                  end else begin
                     row_d = row_q + CNT_W'(1);
                  end
               end else begin
                  col_d = col_q + CNT_W'(1);
               end
            end
         end
         ST_DONE, ST_ERROR: begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         size_i_q   <= '0;
         size_j_q   <= '0;
         row_q      <= '0;
         col_q      <= '0;
         mac_q      <= '0;
         acc_q      <= '0;
         ready_q    <= 1'b0;
         out_i_en_q <= 1'b0;
         out_j_en_q <= 1'b0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         size_i_q   <= size_i_d;
         size_j_q   <= size_j_d;
         row_q      <= row_d;
         col_q      <= col_d;
         mac_q      <= mac_d;
         acc_q      <= acc_d;
         ready_q    <= ready_d;
         out_i_en_q <= out_i_en_d;
         out_j_en_q <= out_j_en_d;
         dout_q     <= dout_d;
      end
   end

   // Matrix buffers; every used location is rewritten before it is read.
   always_ff @(posedge CLK) begin
      b_mem_q <= b_mem_d;
      p_mem_q <= p_mem_d;
   end

   assign bus.READY               = ready_q;
   assign bus.DATA_B_OUT_I_ENABLE = out_i_en_q;
   assign bus.DATA_B_OUT_J_ENABLE = out_j_en_q;
   assign bus.DATA_B_OUT          = dout_q;
endmodule
